// File: rtl/program_sequencer.sv
// Program address sequencer: sequential advance, jump, relative branch,
// and call/return through a small return-address stack with sticky
// overflow/underflow error flags.
module program_sequencer #(
  parameter int              AW         = 32,
  parameter int              STEP       = 4,
  parameter int              DEPTH      = 8,
  parameter logic [AW-1:0]   RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [2:0]                   op,
  input  logic [AW-1:0]                jump_address,
  input  logic [AW-1:0]                branch_offset,
  input  logic                         taken,
  input  logic                         clear_err,
  output logic [AW-1:0]                current_addr,
  output logic [AW-1:0]                next_address,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int DW    = $clog2(DEPTH + 1);
  // Index width is at least one bit so a single-entry stack still has a
  // legal address; the array is sized to cover every index value.
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RETURN = 3'd4
  } op_e;

  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [AW-1:0]        stack_q [SLOTS];

  logic [AW-1:0]        step_addr;
  logic signed [AW-1:0] br_sum;
  logic [IW-1:0]        top_idx;
  logic [IW-1:0]        push_idx;
  logic                 push_req, pop_req;
  logic                 ovf_set, unf_set;
  logic                 push_en;

  // Decode the op into the next address and the stack/flag requests.
  always_comb begin
    step_addr    = addr_q + AW'(STEP);
    br_sum       = $signed(addr_q) + $signed(branch_offset);
    top_idx      = IW'(depth_q - DW'(1));
    push_idx     = IW'(depth_q);
    next_address = step_addr;
    push_req     = 1'b0;
    pop_req      = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    case (op)
      OP_JUMP:   next_address = jump_address;
      OP_BRANCH: if (taken) next_address = $unsigned(br_sum);
      OP_CALL: begin
        next_address = jump_address;
        if (depth_q == DW'(DEPTH)) ovf_set  = 1'b1;
        else                       push_req = 1'b1;
      end
      OP_RETURN: begin
        // An empty stack is never read: fall through to the sequential address.
        if (depth_q != '0) begin
          next_address = stack_q[top_idx];
          pop_req      = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      default: next_address = step_addr;
    endcase
  end

  // Next-state for address, stack depth and sticky flags (set wins over clear).
  always_comb begin
    addr_d  = addr_q;
    depth_d = depth_q;
    if (enable) begin
      addr_d = next_address;
      if (push_req)     depth_d = depth_q + DW'(1);
      else if (pop_req) depth_d = depth_q - DW'(1);
    end
    ovf_d   = (ovf_q & ~clear_err) | (enable & ovf_set);
    unf_d   = (unf_q & ~clear_err) | (enable & unf_set);
    push_en = enable & push_req & ~reset;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= RESET_ADDR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; validity is tracked solely by depth_q.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= step_addr;
  end

  assign current_addr    = addr_q;
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer (AW=32, STEP=4, DEPTH=2): directed scenarios
// followed by random op streams, checked against a queue-based model.
module tb_program_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] jump_address = '0;
  logic [31:0] branch_offset = '0;
  logic        taken = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] current_addr;
  logic [31:0] next_address;
  logic [1:0]  stack_depth;
  logic        stack_overflow;
  logic        stack_underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_addr = '0;
  logic [31:0] m_stack[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  program_sequencer #(
    .AW(32), .STEP(4), .DEPTH(DEPTH), .RESET_ADDR(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op),
    .jump_address(jump_address), .branch_offset(branch_offset),
    .taken(taken), .clear_err(clear_err),
    .current_addr(current_addr), .next_address(next_address),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next();
    case (op)
      3'd1:    return jump_address;
      3'd2:    return taken ? m_addr + branch_offset : m_addr + 32'd4;
      3'd3:    return jump_address;
      3'd4:    return (m_stack.size() > 0) ? m_stack[$] : m_addr + 32'd4;
      default: return m_addr + 32'd4;
    endcase
  endfunction

  // One clock: drive, check combinational target, clock, update model, check state.
  task automatic step(input logic en, input logic [2:0] o, input logic [31:0] ja,
                      input logic [31:0] bo, input logic tk, input logic ce,
                      input logic rs);
    logic [31:0] nxt;
    enable = en; op = o; jump_address = ja; branch_offset = bo;
    taken = tk; clear_err = ce; reset = rs;
    #1;
    nxt = model_next();
    chk("next_address", next_address, nxt);
    @(posedge clk);
    #1;
    if (rs) begin
      m_addr = 32'h0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (en) begin
        if (o == 3'd3) begin
          if (m_stack.size() == DEPTH) m_ovf = 1'b1;
          else m_stack.push_back(m_addr + 32'd4);
        end else if (o == 3'd4) begin
          if (m_stack.size() > 0) void'(m_stack.pop_back());
          else m_unf = 1'b1;
        end
        m_addr = nxt;
      end
    end
    chk("current_addr", current_addr, m_addr);
    chk("stack_depth", {30'd0, stack_depth}, m_stack.size());
    chk("stack_overflow", {31'd0, stack_overflow}, {31'd0, m_ovf});
    chk("stack_underflow", {31'd0, stack_underflow}, {31'd0, m_unf});
  endtask

  initial begin
    // Bring the DUT out of its unknown power-up state.
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, then three NEXT steps
    step(1, 3'd3, 32'h123, 0, 0, 0, 1);
    chk("reset_addr", current_addr, 32'h0);
    step(1, 3'd0, 0, 0, 0, 0, 0);
    step(1, 3'd0, 0, 0, 0, 0, 0);
    step(1, 3'd0, 0, 0, 0, 0, 0);
    chk("next3_addr", current_addr, 32'd12);
    #1 chk("next3_next", next_address, 32'd16);

    // Sequential wrap at the top of the address space
    step(1, 3'd1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(1, 3'd0, 32'h5555_0000, 32'h40, 1, 0, 0);
    chk("wrap_addr", current_addr, 32'h0);
    chk("wrap_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);

    // Backward branch taken, then not taken
    step(1, 3'd1, 32'h100, 0, 0, 0, 0);
    step(1, 3'd2, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1, 0, 0);
    chk("branch_taken", current_addr, 32'hF0);
    step(1, 3'd2, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 0, 0, 0);
    chk("branch_not_taken", current_addr, 32'hF4);

    // Nested calls past stack capacity, then unwind
    step(1, 3'd1, 32'h10, 0, 0, 0, 0);
    step(1, 3'd3, 32'h200, 0, 0, 0, 0);
    step(1, 3'd3, 32'h300, 0, 0, 0, 0);
    step(1, 3'd3, 32'h400, 0, 0, 0, 0);
    chk("ovf_addr", current_addr, 32'h400);
    chk("ovf_depth", {30'd0, stack_depth}, 32'd2);
    chk("ovf_flag", {31'd0, stack_overflow}, 32'd1);
    step(1, 3'd4, 0, 0, 0, 0, 0);
    chk("ret1", current_addr, 32'h204);
    step(1, 3'd4, 0, 0, 0, 0, 0);
    chk("ret2", current_addr, 32'h14);

    // Underflow on empty stack, clear, and set-wins-over-clear
    step(1, 3'd1, 32'h40, 0, 0, 1, 0);
    step(1, 3'd4, 32'h999, 0, 1, 0, 0);
    chk("unf_addr", current_addr, 32'h44);
    chk("unf_flag", {31'd0, stack_underflow}, 32'd1);
    step(0, 3'd0, 0, 0, 0, 1, 0);
    chk("unf_cleared", {31'd0, stack_underflow}, 32'd0);
    step(1, 3'd4, 0, 0, 0, 1, 0);
    chk("unf_set_wins", {31'd0, stack_underflow}, 32'd1);
    step(1, 3'd0, 0, 0, 0, 1, 0);

    // Reserved op codes act as NEXT without touching flags
    for (int r = 5; r < 8; r++) step(1, 3'(r), $urandom, $urandom, 1, 0, 0);

    // Disabled CALL holds everything; reset beats an enabled CALL
    step(1, 3'd3, 32'h800, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 3'd3, 32'hA00, 0, 0, 0, 0);
    chk("hold_addr", current_addr, 32'h800);
    step(1, 3'd3, 32'hB00, 0, 0, 0, 1);
    chk("rst_call_addr", current_addr, 32'h0);
    chk("rst_call_depth", {30'd0, stack_depth}, 32'd0);
    step(1, 3'd4, 0, 0, 0, 0, 0);

    // Random op streams
    for (int i = 0; i < 400; i++) begin
      logic [2:0] ro;
      ro = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      step(($urandom_range(0, 3) != 0), ro, $urandom,
           ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32,
           1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
